// File: rtl/sqrt_fixed_iter.sv
// rtl/sqrt_fixed_iter.sv - bit-serial restoring square root, floor(sqrt(n)*2^F_W)
// One result bit per CALC cycle; valid/ready on operand and result sides.
module sqrt_fixed_iter #(
  parameter int N_W = 4,
  parameter int F_W = 10,
  localparam int R_W = (N_W + 1) / 2 + F_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] in_n,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [R_W-1:0] out_root,
  output logic           out_exact
);

  localparam int RAD_W = 2 * R_W;
  localparam int CNT_W = $clog2(R_W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state, w_state_nx;
  logic [RAD_W-1:0]   r_rad;
  logic [R_W+1:0]     r_rem;
  logic [R_W-1:0]     r_root;
  logic [CNT_W-1:0]   r_cnt;
  logic [R_W-1:0]     r_out_root;
  logic               r_out_exact;

  logic [RAD_W-1:0]   w_rad_init;
  logic [R_W+1:0]     w_r2;
  logic [R_W+1:0]     w_t;
  logic               w_ge;
  logic [R_W+1:0]     w_rem_nx;
  logic [R_W-1:0]     w_root_nx;
  logic               w_last;

  // Operand lands in the top of the radicand; the odd-width pad bit stays zero.
  assign w_rad_init = RAD_W'(in_n) << (2 * F_W);

  assign w_r2      = (r_rem << 2) | (R_W + 2)'(r_rad[RAD_W-1 -: 2]);
  assign w_t       = {r_root, 2'b01};
  assign w_ge      = (w_r2 >= w_t);
  assign w_rem_nx  = w_ge ? (w_r2 - w_t) : w_r2;
  assign w_root_nx = {r_root[R_W-2:0], w_ge};
  assign w_last    = (r_cnt == CNT_W'(R_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nx = S_CALC;
      S_CALC:  if (w_last)    w_state_nx = S_DONE;
      S_DONE:  if (out_ready) w_state_nx = S_IDLE;
      default:                w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_cnt       <= '0;
      r_out_root  <= '0;
      r_out_exact <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rad  <= w_rad_init;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
          end
        end
        S_CALC: begin
          r_rad  <= r_rad << 2;
          r_rem  <= w_rem_nx;
          r_root <= w_root_nx;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_out_root  <= w_root_nx;
            r_out_exact <= (w_rem_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_root  = r_out_root;
  assign out_exact = r_out_exact;

endmodule

// File: tb/tb_sqrt_fixed_iter.sv
// tb/tb_sqrt_fixed_iter.sv - self-checking bench for sqrt_fixed_iter
// Two instances: default (N_W=4,F_W=10) and N_W=9,F_W=3.
module tb_sqrt_fixed_iter;

  logic clk = 1'b0;
  logic rst;

  logic        iv_a, ir_a, ov_a, ordy_a, ex_a;
  logic [3:0]  n_a;
  logic [11:0] root_a;

  logic        iv_b, ir_b, ov_b, ordy_b, ex_b;
  logic [8:0]  n_b;
  logic [7:0]  root_b;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic        cur_ir, cur_ov, cur_ex;
  logic [31:0] cur_root;

  always #5 clk = ~clk;

  sqrt_fixed_iter #(.N_W(4), .F_W(10)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(iv_a), .in_ready(ir_a), .in_n(n_a),
    .out_valid(ov_a), .out_ready(ordy_a), .out_root(root_a), .out_exact(ex_a)
  );

  sqrt_fixed_iter #(.N_W(9), .F_W(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(iv_b), .in_ready(ir_b), .in_n(n_b),
    .out_valid(ov_b), .out_ready(ordy_b), .out_root(root_b), .out_exact(ex_b)
  );

  always_comb begin
    if (sel == 0) begin
      cur_ir = ir_a; cur_ov = ov_a; cur_ex = ex_a; cur_root = 32'(root_a);
    end else begin
      cur_ir = ir_b; cur_ov = ov_b; cur_ex = ex_b; cur_root = 32'(root_b);
    end
  end

  // Largest r with r*r <= v, by binary search.
  function automatic longint isqrt(input longint v);
    longint lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 26;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input int s, input logic v, input int n);
    if (s == 0) begin iv_a = v; n_a = 4'(n); end
    else        begin iv_b = v; n_b = 9'(n); end
  endtask

  task automatic set_ready(input int s, input logic r);
    if (s == 0) ordy_a = r;
    else        ordy_b = r;
  endtask

  // One operand through the selected unit, with `hold` cycles of backpressure.
  task automatic op(input int s, input int n, input int hold, input string tag,
                    output logic [31:0] got);
    int fw, rw, g, lat;
    longint v, r;
    sel = s;
    fw = (s == 0) ? 10 : 3;
    rw = (s == 0) ? 12 : 8;
    v = longint'(n) << (2 * fw);
    r = isqrt(v);
    @(negedge clk);
    g = 0;
    while (!cur_ir && g < 50) begin @(negedge clk); g++; end
    check({tag, " in_ready"}, 32'(cur_ir), 32'd1);
    drive_in(s, 1'b1, n);
    @(negedge clk);
    drive_in(s, 1'b0, 0);
    lat = 0;
    while (!cur_ov && lat < 100) begin @(negedge clk); lat++; end
    check({tag, " latency"}, 32'(lat), 32'(rw));
    repeat (hold) @(negedge clk);
    got = cur_root;
    check({tag, " root"}, cur_root, 32'(r));
    check({tag, " exact"}, 32'(cur_ex), 32'(r * r == v));
    set_ready(s, 1'b1);
    @(negedge clk);
    set_ready(s, 1'b0);
    check({tag, " idle after handshake"}, {30'd0, cur_ir, cur_ov}, 32'd2);
    check({tag, " root kept"}, cur_root, 32'(r));
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] res_q[$];
    int          t_q[$];
    int          idx, cyc, bad, vcount;
    longint      v;

    rst = 1'b1;
    iv_a = 1'b0; n_a = '0; ordy_a = 1'b0;
    iv_b = 1'b0; n_b = '0; ordy_b = 1'b0;
    @(negedge clk);
    check("reset a", {ir_a, ov_a, ex_a, 12'(root_a)}, {3'b100, 12'd0});
    check("reset b", {ir_b, ov_b, ex_b, 8'(root_b)}, {3'b100, 8'd0});
    @(negedge clk);
    rst = 1'b0;

    op(0, 2, 0, "a n=2", got);  check("a n=2 const", got, 32'h5A8);
    op(0, 0, 1, "a n=0", got);  check("a n=0 const", got, 32'h000);
    op(0, 9, 0, "a n=9", got);  check("a n=9 const", got, 32'hC00);
    op(0, 15, 2, "a n=15", got); check("a n=15 const", got, 32'hF7D);

    // Backpressure: 20 cycles with out_ready low.
    sel = 0;
    @(negedge clk);
    iv_a = 1'b1; n_a = 4'd4;
    @(negedge clk);
    iv_a = 1'b0;
    cyc = 0;
    while (!ov_a && cyc < 100) begin @(negedge clk); cyc++; end
    check("bp latency", 32'(cyc), 32'd12);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (root_a !== 12'h800 || ir_a !== 1'b0 || ov_a !== 1'b1) bad++;
      @(negedge clk);
    end
    check("bp held cycles bad", 32'(bad), 32'd0);
    ordy_a = 1'b1;
    @(negedge clk);
    ordy_a = 1'b0;
    check("bp in_ready after", 32'(ir_a), 32'd1);

    // Reset during the 5th CALC cycle discards the pending result.
    @(negedge clk);
    iv_a = 1'b1; n_a = 4'd7;
    @(negedge clk);
    iv_a = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid reset state", {30'd0, ir_a, ov_a}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (ov_a) vcount++;
      @(negedge clk);
    end
    check("no valid after reset", 32'(vcount), 32'd0);
    op(0, 3, 0, "a n=3", got); check("a n=3 const", got, 32'h6ED);

    // Back-to-back 1..15 with out_ready and in_valid held high.
    sel = 0;
    ordy_a = 1'b1;
    idx = 0;
    cyc = 0;
    while (res_q.size() < 15 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ov_a) begin res_q.push_back(32'(root_a)); t_q.push_back(cyc); end
      if (ir_a) begin
        if (idx < 15) begin n_a = 4'(idx + 1); iv_a = 1'b1; idx++; end
        else iv_a = 1'b0;
      end
    end
    iv_a = 1'b0;
    @(negedge clk);
    ordy_a = 1'b0;
    check("b2b count", 32'(res_q.size()), 32'd15);
    bad = 0;
    for (int i = 0; i < res_q.size(); i++) begin
      v = longint'(i + 1) << 20;
      if (res_q[i] !== 32'(isqrt(v))) bad++;
      if (i > 0 && (t_q[i] - t_q[i-1]) != 14) bad++;
    end
    check("b2b roots/spacing bad", 32'(bad), 32'd0);

    for (int i = 0; i < 10; i++)
      op(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "a rand", got);

    op(1, 511, 0, "b n=511", got); check("b n=511 const", got, 32'hB4);
    op(1, 256, 1, "b n=256", got); check("b n=256 const", got, 32'h80);
    op(1, 0, 0, "b n=0", got);
    for (int i = 0; i < 20; i++)
      op(1, int'($urandom_range(0, 511)), int'($urandom_range(0, 3)), "b rand", got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
